// File: rtl/hpi_target.sv
// Host-port target: 16-bit register window onto local word memory plus two mailboxes.
// Optional build macro HPI_TARGET_ERRCNT_EN adds an 8-bit saturating ignored-strobe counter.
module hpi_target #(
  parameter int MEM_AW = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_int,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr
`ifdef HPI_TARGET_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_MBX    = 2'd1;
  localparam logic [1:0] A_ADDR   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;
  localparam int         DEPTH    = 1 << MEM_AW;

  logic [15:0]       r_mem [0:DEPTH-1];
  logic              r_active;
  logic [15:0]       r_address;
  logic [15:0]       r_dout;
  logic [15:0]       r_mbx_in;
  logic              r_mbx_in_f;
  logic [15:0]       r_mbx_out;
  logic              r_mbx_out_f;

  logic              w_any;
  logic              w_start;
  logic              w_rd_start;
  logic              w_wr_start;
  logic              w_bad_start;
  logic [MEM_AW-1:0] w_idx;

  // One access per strobe assertion: start only when the previous cycle had no strobe.
  assign w_any       = !hpi_cs_n && (!hpi_r_n || !hpi_w_n);
  assign w_start     = w_any && !r_active;
  assign w_rd_start  = w_start && !hpi_r_n &&  hpi_w_n;
  assign w_wr_start  = w_start &&  hpi_r_n && !hpi_w_n;
  assign w_bad_start = w_start && !hpi_r_n && !hpi_w_n;
  assign w_idx       = r_address[MEM_AW:1];

  assign hpi_data_out = r_dout;
  assign hpi_int      = r_mbx_out_f;
  assign mbx_in_data  = r_mbx_in;
  assign mbx_in_valid = r_mbx_in_f;

  always_ff @(posedge clk_clk) begin
    if (w_wr_start && hpi_addr == A_DATA)
      r_mem[w_idx] <= hpi_data_in;
  end

  // Tracker resets to "active" so a strobe held through reset release is not an access.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_active  <= 1'b1;
      r_address <= 16'h0000;
    end else begin
      r_active <= w_any;
      if (w_wr_start && hpi_addr == A_ADDR)
        r_address <= hpi_data_in;
      else if ((w_wr_start || w_rd_start) && hpi_addr == A_DATA)
        r_address <= r_address + 16'd2;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_dout <= 16'h0000;
    end else if (w_rd_start) begin
      case (hpi_addr)
        A_DATA:   r_dout <= r_mem[w_idx];
        A_MBX:    r_dout <= r_mbx_out;
        A_ADDR:   r_dout <= r_address;
        A_STATUS: r_dout <= {14'b0, r_mbx_out_f, r_mbx_in_f};
        default:  r_dout <= r_dout;
      endcase
    end
  end

  // Host write wins over a same-cycle local acknowledge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_mbx_in   <= 16'h0000;
      r_mbx_in_f <= 1'b0;
    end else if (w_wr_start && hpi_addr == A_MBX) begin
      r_mbx_in   <= hpi_data_in;
      r_mbx_in_f <= 1'b1;
    end else if (mbx_in_ack && r_mbx_in_f) begin
      r_mbx_in_f <= 1'b0;
    end
  end

  // Local post wins over a same-cycle host read; the read still returns the old word.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_mbx_out   <= 16'h0000;
      r_mbx_out_f <= 1'b0;
    end else if (mbx_out_wr) begin
      r_mbx_out   <= mbx_out_data;
      r_mbx_out_f <= 1'b1;
    end else if (w_rd_start && hpi_addr == A_MBX) begin
      r_mbx_out_f <= 1'b0;
    end
  end

`ifdef HPI_TARGET_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)
      r_err_cnt <= 8'h00;
    else if (w_bad_start && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_hpi_target.sv
// Directed bench for hpi_target: memory window, address wrap, mailboxes, strobe edge rules.
module tb_hpi_target;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_int;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;
`ifdef HPI_TARGET_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] rd;

  hpi_target #(.MEM_AW(8)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .hpi_addr(hpi_addr),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .hpi_int(hpi_int),
    .mbx_in_data(mbx_in_data), .mbx_in_valid(mbx_in_valid), .mbx_in_ack(mbx_in_ack),
    .mbx_out_data(mbx_out_data), .mbx_out_wr(mbx_out_wr)
`ifdef HPI_TARGET_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
  endtask

  task automatic hwr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_clk);
    hpi_addr = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    @(negedge clk_clk);
    idle();
  endtask

  task automatic hrd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk_clk);
    hpi_addr = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    @(negedge clk_clk);
    idle();
    d = hpi_data_out;
  endtask

  initial begin
    reset_reset = 1'b1; idle(); hpi_addr = 2'd0; hpi_data_in = 16'h0;
    mbx_in_ack = 1'b0; mbx_out_data = 16'h0; mbx_out_wr = 1'b0;
    repeat (3) @(negedge clk_clk);
    chk("rst_dout", hpi_data_out, 16'h0000);
    chk("rst_int", {15'b0, hpi_int}, 16'h0000);
    chk("rst_valid", {15'b0, mbx_in_valid}, 16'h0000);
    chk("rst_mbx_in_data", mbx_in_data, 16'h0000);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    hrd(2'd3, rd); chk("rst_status", rd, 16'h0000);
    hrd(2'd2, rd); chk("rst_address", rd, 16'h0000);

    // Sequential memory access with auto-increment
    hwr(2'd2, 16'h0010);
    hwr(2'd0, 16'hAAAA);
    hwr(2'd0, 16'hBBBB);
    hwr(2'd2, 16'h0010);
    hrd(2'd0, rd); chk("data_rd0", rd, 16'hAAAA);
    hrd(2'd0, rd); chk("data_rd1", rd, 16'hBBBB);
    hrd(2'd2, rd); chk("addr_after", rd, 16'h0014);
    hwr(2'd2, 16'h0040);
    chk("dout_held", hpi_data_out, 16'h0014);

    // Address wrap and memory aliasing
    hwr(2'd2, 16'hFFFE);
    hwr(2'd0, 16'h1234);
    hrd(2'd2, rd); chk("addr_wrap", rd, 16'h0000);
    hwr(2'd2, 16'h01FE);
    hwr(2'd0, 16'h7777);
    hwr(2'd2, 16'h03FE);
    hrd(2'd0, rd); chk("alias", rd, 16'h7777);

    // Inbound mailbox
    hwr(2'd1, 16'h5A5A);
    chk("mbxin_valid", {15'b0, mbx_in_valid}, 16'h0001);
    chk("mbxin_data", mbx_in_data, 16'h5A5A);
    hrd(2'd3, rd); chk("status_in", rd, 16'h0001);
    @(negedge clk_clk); mbx_in_ack = 1'b1;
    @(negedge clk_clk); mbx_in_ack = 1'b0;
    chk("mbxin_acked", {15'b0, mbx_in_valid}, 16'h0000);
    hrd(2'd3, rd); chk("status_acked", rd, 16'h0000);
    hwr(2'd1, 16'h1111);
    @(negedge clk_clk);
    hpi_addr = 2'd1; hpi_data_in = 16'h2222; hpi_cs_n = 1'b0; hpi_w_n = 1'b0; mbx_in_ack = 1'b1;
    @(negedge clk_clk);
    idle(); mbx_in_ack = 1'b0;
    chk("wr_ack_valid", {15'b0, mbx_in_valid}, 16'h0001);
    chk("wr_ack_data", mbx_in_data, 16'h2222);
    @(negedge clk_clk); mbx_in_ack = 1'b1;
    @(negedge clk_clk); mbx_in_ack = 1'b0;

    // Outbound mailbox
    @(negedge clk_clk); mbx_out_wr = 1'b1; mbx_out_data = 16'hC0DE;
    @(negedge clk_clk); mbx_out_wr = 1'b0;
    chk("int_set", {15'b0, hpi_int}, 16'h0001);
    hrd(2'd3, rd); chk("status_out", rd, 16'h0002);
    hrd(2'd1, rd); chk("mbxout_rd", rd, 16'hC0DE);
    chk("int_clr", {15'b0, hpi_int}, 16'h0000);
    @(negedge clk_clk); mbx_out_wr = 1'b1; mbx_out_data = 16'h1111;
    @(negedge clk_clk); mbx_out_wr = 1'b0;
    hpi_addr = 2'd1; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; mbx_out_wr = 1'b1; mbx_out_data = 16'hBEEF;
    @(negedge clk_clk);
    idle(); mbx_out_wr = 1'b0;
    chk("race_old", hpi_data_out, 16'h1111);
    chk("race_int", {15'b0, hpi_int}, 16'h0001);
    hrd(2'd1, rd); chk("race_new", rd, 16'hBEEF);
    chk("race_int_clr", {15'b0, hpi_int}, 16'h0000);

    // Long strobe yields one access
    hwr(2'd2, 16'h0022);
    hwr(2'd0, 16'h4444);
    hwr(2'd2, 16'h0020);
    @(negedge clk_clk);
    hpi_addr = 2'd0; hpi_data_in = 16'h9999; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    repeat (10) @(negedge clk_clk);
    idle();
    hrd(2'd2, rd); chk("long_addr", rd, 16'h0022);
    hwr(2'd2, 16'h0020);
    hrd(2'd0, rd); chk("long_word0", rd, 16'h9999);
    hrd(2'd0, rd); chk("long_word1", rd, 16'h4444);

    // STATUS writes ignored
    hwr(2'd3, 16'hFFFF);
    hrd(2'd3, rd); chk("status_wr_ign", rd, 16'h0000);

    // Both strobes low: ignored
    hwr(2'd2, 16'h0030);
    @(negedge clk_clk);
    hpi_addr = 2'd0; hpi_data_in = 16'hFFFF; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
    @(negedge clk_clk);
    idle();
    hrd(2'd2, rd); chk("both_addr", rd, 16'h0030);
`ifdef HPI_TARGET_ERRCNT_EN
    chk("err_cnt", {8'b0, err_cnt}, 16'h0001);
`endif

    // Strobe held across reset release
    hwr(2'd2, 16'h0000);
    hwr(2'd0, 16'h0101);
    @(negedge clk_clk); mbx_out_wr = 1'b1; mbx_out_data = 16'h3333;
    @(negedge clk_clk); mbx_out_wr = 1'b0;
    reset_reset = 1'b1;
    hpi_addr = 2'd0; hpi_data_in = 16'hDEAD; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    @(negedge clk_clk);
    chk("rst2_int", {15'b0, hpi_int}, 16'h0000);
    chk("rst2_dout", hpi_data_out, 16'h0000);
    @(negedge clk_clk); reset_reset = 1'b0;
    repeat (3) @(negedge clk_clk);
    idle();
    hrd(2'd2, rd); chk("held_rst_addr", rd, 16'h0000);
    hrd(2'd0, rd); chk("held_rst_mem", rd, 16'h0101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
